imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 166 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a main/skid output buffer, ordered delivery and an illegal-opcode counter.
// Build option: define IMM_GEN_ZICSR_EN to decode CSR-immediate forms (opcode 1110011, funct3[2]=1) as Z-type.
module imm_gen_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           in_instr,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_sextimm,
   output logic [2:0]            out_imm_type,
   output logic                  out_illegal,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [15:0]           illegal_cnt
);

   localparam logic [2:0] T_NONE = 3'd0;
   localparam logic [2:0] T_I    = 3'd1;
   localparam logic [2:0] T_S    = 3'd2;
   localparam logic [2:0] T_B    = 3'd3;
   localparam logic [2:0] T_U    = 3'd4;
   localparam logic [2:0] T_J    = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
   localparam logic [2:0] T_Z    = 3'd6;
`endif

   typedef struct packed {
      logic [DATA_WIDTH-1:0] imm;
      logic [2:0]            typ;
      logic                  ill;
      logic [TAG_WIDTH-1:0]  tag;
   } entry_t;

   logic [31:0] w_imm32;
   logic [2:0]  w_type;
   logic        w_ill;
   logic [DATA_WIDTH-1:0] w_imm;
   entry_t      w_dec;

   always_comb begin
      w_imm32 = '0;
      w_type  = T_NONE;
      w_ill   = 1'b0;
      case (in_instr[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: begin
            w_type  = T_I;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         end
         7'b0100011: begin
            w_type  = T_S;
            w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         end
         7'b1100011: begin
            w_type  = T_B;
            w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                       in_instr[11:8], 1'b0};
         end
         7'b0110111, 7'b0010111: begin
            w_type  = T_U;
            w_imm32 = {in_instr[31:12], 12'b0};
         end
         7'b1101111: begin
            w_type  = T_J;
            w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                       in_instr[30:21], 1'b0};
         end
         7'b0110011, 7'b0001111: w_type = T_NONE;
         7'b1110011: begin
`ifdef IMM_GEN_ZICSR_EN
            if (in_instr[14]) begin
               w_type  = T_Z;
               w_imm32 = {27'b0, in_instr[19:15]};
            end
`else
            w_type = T_NONE;
`endif
         end
         // RV64 word-ops only exist when the datapath is 64 bits wide.
         7'b0011011: begin
            if (DATA_WIDTH == 64) begin
               w_type  = T_I;
               w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end else begin
               w_ill = 1'b1;
            end
         end
         7'b0111011: w_ill = (DATA_WIDTH != 64);
         default:    w_ill = 1'b1;
      endcase
      if (in_instr[1:0] != 2'b11) w_ill = 1'b1;
      if (w_ill) begin
         w_type  = T_NONE;
         w_imm32 = '0;
      end
   end

   generate
      if (DATA_WIDTH > 32) begin : g_wide
         assign w_imm = {{(DATA_WIDTH-32){w_imm32[31]}}, w_imm32};
      end else begin : g_narrow
         assign w_imm = w_imm32;
      end
   endgenerate

   assign w_dec = '{imm: w_imm, typ: w_type, ill: w_ill, tag: in_tag};

   // Handshake: a transfer happens on a cycle where valid and ready are both 1 at the rising edge;
   // valid never depends on ready, and in_ready is a flop equal to NOT(skid valid).
   entry_t      r_main, r_skid;
   logic        r_main_valid, r_skid_valid, r_in_ready;
   logic [15:0] r_cnt;
   logic        w_acc, w_deq;
   logic        w_main_load_skid, w_main_load_in, w_skid_load_in;
   logic        w_main_valid_nxt, w_skid_valid_nxt;

   always_comb begin
      w_acc            = in_valid & r_in_ready;
      w_deq            = r_main_valid & out_ready;
      w_main_load_skid = w_deq & r_skid_valid;
      w_main_load_in   = w_acc & (~r_main_valid | (w_deq & ~r_skid_valid));
      w_skid_load_in   = w_acc & ~w_main_load_in;
      w_main_valid_nxt = w_main_load_skid | w_main_load_in | (r_main_valid & ~w_deq);
      w_skid_valid_nxt = w_skid_load_in | (r_skid_valid & ~w_deq);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
         r_cnt        <= '0;
      end else begin
         if (w_main_load_skid)    r_main <= r_skid;
         else if (w_main_load_in) r_main <= w_dec;
         if (w_skid_load_in)      r_skid <= w_dec;
         // Flush only kills the valids; a handshake already under way still counts below.
         if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
         end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
         end
         if (w_deq && r_main.ill && (r_cnt != 16'hFFFF)) r_cnt <= r_cnt + 16'd1;
      end
   end

   assign in_ready     = r_in_ready;
   assign out_valid    = r_main_valid;
   assign out_sextimm  = r_main.imm;
   assign out_imm_type = r_main.typ;
   assign out_illegal  = r_main.ill;
   assign out_tag      = r_main.tag;
   assign illegal_cnt  = r_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 32-bit and a 64-bit instance checked against hand-computed immediates.
module tb_imm_gen_pipe;

   logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
   logic [31:0] in_instr, out_sextimm;
   logic [3:0]  in_tag, out_tag;
   logic [2:0]  out_imm_type;
   logic [15:0] illegal_cnt;

   logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
   logic [31:0] in_instr64;
   logic [63:0] out_sextimm64;
   logic [3:0]  in_tag64, out_tag64;
   logic [2:0]  out_imm_type64;
   logic [15:0] illegal_cnt64;

   int          n_checks, n_errors;
   logic [15:0] exp_cnt;

   imm_gen_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(4)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_sextimm(out_sextimm),
      .out_imm_type(out_imm_type), .out_illegal(out_illegal), .out_tag(out_tag),
      .illegal_cnt(illegal_cnt)
   );

   imm_gen_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(4)) dut64 (
      .clk(clk), .reset(reset), .flush(flush64),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_tag(in_tag64),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_sextimm(out_sextimm64),
      .out_imm_type(out_imm_type64), .out_illegal(out_illegal64), .out_tag(out_tag64),
      .illegal_cnt(illegal_cnt64)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic single(input logic [31:0] instr, input logic [31:0] e_imm,
                         input logic [2:0] e_type, input logic e_ill, input logic [3:0] tg);
      in_valid  = 1'b1;
      in_instr  = instr;
      in_tag    = tg;
      out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("vld_%h", instr), {63'd0, out_valid}, 64'd1);
      chk($sformatf("imm_%h", instr), {32'd0, out_sextimm}, {32'd0, e_imm});
      chk($sformatf("typ_%h", instr), {61'd0, out_imm_type}, {61'd0, e_type});
      chk($sformatf("ill_%h", instr), {63'd0, out_illegal}, {63'd0, e_ill});
      chk($sformatf("tag_%h", instr), {60'd0, out_tag}, {60'd0, tg});
      in_valid = 1'b0;
      @(negedge clk);
      if (e_ill && exp_cnt != 16'hFFFF) exp_cnt++;
      chk($sformatf("drain_%h", instr), {63'd0, out_valid}, 64'd0);
      chk($sformatf("cnt_%h", instr), {48'd0, illegal_cnt}, {48'd0, exp_cnt});
   endtask

   task automatic single64(input logic [31:0] instr, input logic [63:0] e_imm,
                           input logic [2:0] e_type, input logic e_ill);
      in_valid64  = 1'b1;
      in_instr64  = instr;
      in_tag64    = instr[3:0] ^ 4'hA;
      out_ready64 = 1'b1;
      @(negedge clk);
      chk($sformatf("v64_%h", instr), {63'd0, out_valid64}, 64'd1);
      chk($sformatf("imm64_%h", instr), out_sextimm64, e_imm);
      chk($sformatf("typ64_%h", instr), {61'd0, out_imm_type64}, {61'd0, e_type});
      chk($sformatf("ill64_%h", instr), {63'd0, out_illegal64}, {63'd0, e_ill});
      chk($sformatf("tag64_%h", instr), {60'd0, out_tag64}, {60'd0, instr[3:0] ^ 4'hA});
      in_valid64 = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_errors = 0; exp_cnt = '0;
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b0;
      flush64 = 1'b0; in_valid64 = 1'b0; in_instr64 = '0; in_tag64 = '0; out_ready64 = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_vld", {63'd0, out_valid}, 64'd0);
      chk("rst_rdy", {63'd0, in_ready}, 64'd1);
      chk("rst_imm", {32'd0, out_sextimm}, 64'd0);
      chk("rst_typ", {61'd0, out_imm_type}, 64'd0);
      chk("rst_ill", {63'd0, out_illegal}, 64'd0);
      chk("rst_tag", {60'd0, out_tag}, 64'd0);
      chk("rst_cnt", {48'd0, illegal_cnt}, 64'd0);
      reset = 1'b0;

      // accepted on the first edge after reset; two illegal zeros
      single(32'h00000000, 32'h0, 3'd0, 1'b1, 4'h1);
      single(32'h00000000, 32'h0, 3'd0, 1'b1, 4'h2);
      chk("cnt_two", {48'd0, illegal_cnt}, 64'd2);

      single(32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 4'h3);
      single(32'h7FF00013, 32'h000007FF, 3'd1, 1'b0, 4'h4);
      single(32'h80002003, 32'hFFFFF800, 3'd1, 1'b0, 4'h5);
      single(32'h00112623, 32'h0000000C, 3'd2, 1'b0, 4'h6);
      single(32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 4'h7);
      single(32'h800000B7, 32'h80000000, 3'd4, 1'b0, 4'h8);
      single(32'h12345037, 32'h12345000, 3'd4, 1'b0, 4'h9);
      single(32'h0000006F, 32'h00000000, 3'd5, 1'b0, 4'hA);
      single(32'h8000006F, 32'hFFF00000, 3'd5, 1'b0, 4'hB);
      single(32'h00000033, 32'h0, 3'd0, 1'b0, 4'hC);
      single(32'h0000000F, 32'h0, 3'd0, 1'b0, 4'hD);
      single(32'h00000073, 32'h0, 3'd0, 1'b0, 4'hE);
      single(32'h0000001B, 32'h0, 3'd0, 1'b1, 4'hF);
      single(32'h0000003B, 32'h0, 3'd0, 1'b1, 4'h0);
      single(32'hFFF00090, 32'h0, 3'd0, 1'b1, 4'h1);
      single(32'h0000005B, 32'h0, 3'd0, 1'b1, 4'h2);
`ifdef IMM_GEN_ZICSR_EN
      single(32'h3401D073, 32'h00000003, 3'd6, 1'b0, 4'h3);
      single(32'h34011073, 32'h0, 3'd0, 1'b0, 4'h4);
`else
      single(32'h3401D073, 32'h0, 3'd0, 1'b0, 4'h3);
      single(32'h34011073, 32'h0, 3'd0, 1'b0, 4'h4);
`endif

      // 64-bit instance
      single64(32'h800000B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      single64(32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      single64(32'h0000001B, 64'h0, 3'd1, 1'b0);
      single64(32'h0000003B, 64'h0, 3'd0, 1'b0);
      single64(32'h7FF00013, 64'h00000000000007FF, 3'd1, 1'b0);
      single64(32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
      chk("cnt64", {48'd0, illegal_cnt64}, 64'd0);

      // back-to-back with stalled output, then drain in order
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 4'h1;
      @(negedge clk);
      chk("b2b_rdy1", {63'd0, in_ready}, 64'd1);
      in_instr = 32'h0000006F; in_tag = 4'h2;
      @(negedge clk);
      chk("b2b_rdy2", {63'd0, in_ready}, 64'd0);
      in_instr = 32'h00112623; in_tag = 4'h3;
      @(negedge clk);
      chk("b2b_hold_imm", {32'd0, out_sextimm}, 64'hFFFFFFFC);
      chk("b2b_hold_tag", {60'd0, out_tag}, 64'd1);
      chk("b2b_hold_rdy", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("b2b_o2_imm", {32'd0, out_sextimm}, 64'd0);
      chk("b2b_o2_typ", {61'd0, out_imm_type}, 64'd5);
      chk("b2b_o2_tag", {60'd0, out_tag}, 64'd2);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_o3_vld", {63'd0, out_valid}, 64'd1);
      chk("b2b_o3_imm", {32'd0, out_sextimm}, 64'd12);
      chk("b2b_o3_tag", {60'd0, out_tag}, 64'd3);
      @(negedge clk);
      chk("b2b_empty", {63'd0, out_valid}, 64'd0);

      // flush with both stages full and an input offered
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 4'h1;
      @(negedge clk);
      in_instr = 32'h0000006F; in_tag = 4'h2;
      @(negedge clk);
      chk("fl_full", {63'd0, in_ready}, 64'd0);
      in_instr = 32'h00000000; in_tag = 4'h7; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("fl_vld", {63'd0, out_valid}, 64'd0);
      chk("fl_rdy", {63'd0, in_ready}, 64'd1);
      out_ready = 1'b1;
      @(negedge clk);
      chk("fl_none1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("fl_none2", {63'd0, out_valid}, 64'd0);
      chk("fl_cnt", {48'd0, illegal_cnt}, {48'd0, exp_cnt});

      // flush cycle with an illegal handshake and an accepted input
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 4'h3;
      @(negedge clk);
      in_instr = 32'hFFF00093; in_tag = 4'h4; flush = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      exp_cnt++;
      flush = 1'b0; in_valid = 1'b0;
      chk("flh_vld", {63'd0, out_valid}, 64'd0);
      chk("flh_rdy", {63'd0, in_ready}, 64'd1);
      chk("flh_cnt", {48'd0, illegal_cnt}, {48'd0, exp_cnt});
      @(negedge clk);
      chk("flh_drop", {63'd0, out_valid}, 64'd0);

      // saturation: stream enough illegal instructions to pass 0xFFFF
      in_valid = 1'b1; in_instr = 32'h00000000; in_tag = 4'h5; out_ready = 1'b1;
      repeat (65540) @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("sat_cnt", {48'd0, illegal_cnt}, 64'hFFFF);

      // reset asserted mid-operation with both stages full
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFE000EE3; in_tag = 4'h1;
      @(negedge clk);
      in_instr = 32'h0000006F; in_tag = 4'h2;
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("mrst_vld", {63'd0, out_valid}, 64'd0);
      chk("mrst_rdy", {63'd0, in_ready}, 64'd1);
      chk("mrst_imm", {32'd0, out_sextimm}, 64'd0);
      chk("mrst_tag", {60'd0, out_tag}, 64'd0);
      chk("mrst_cnt", {48'd0, illegal_cnt}, 64'd0);
      @(negedge clk);
      reset = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("mrst_none1", {63'd0, out_valid}, 64'd0);
      @(negedge clk);
      chk("mrst_none2", {63'd0, out_valid}, 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
